tile_write_arbiter: RTL and testbench
=====================================

TILE_WRITE_ARBITER -- requirements
Module: tile_write_arbiter

Interface
REQ-001 Parameter NUM_TILES, default 200, number of tile RAM entries (20x10 board, both players).
REQ-002 Parameter CLEAR_VALUE, default 4'h0, tile code written during board clear.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 vid_on  in  1  high during active video, low during blanking.
REQ-007 clear_req  in  1  single-cycle pulse requesting a full-board clear.
REQ-008 clear_busy  out  1  high while a clear sequence is running.
REQ-009 clear_done  out  1  single-cycle pulse after the last clear write.
REQ-010 a_valid, a_ready, a_addr[7:0], a_data[3:0]  in/out/in/in  local game-logic write channel.
REQ-011 b_valid, b_ready, b_addr[7:0], b_data[3:0]  in/out/in/in  remote-link write channel.
REQ-012 ram_we, ram_addr[7:0], ram_wdata[3:0]  out  registered write port to the tile RAM.
REQ-013 err_addr  out  1  sticky flag: a write with address >= NUM_TILES was accepted.

Function
REQ-014 States: IDLE and CLEAR.
REQ-015 Transfer on a channel occurs at a rising edge where valid and ready are both high; x_ready is combinational from state, the valid inputs and last_grant.
REQ-016 In IDLE with clear_req low, at most one ready is high per cycle: the only valid channel, or on a tie the channel not in last_grant (round-robin).
REQ-017 last_grant updates to the granted channel on every transfer.
REQ-018 Accepted write appears on ram_we/ram_addr/ram_wdata in the next cycle (latency 1); back-to-back transfers sustain one write per cycle.
REQ-019 Accepted address >= NUM_TILES: ram_we stays low that cycle and err_addr sets.
REQ-020 ram_we is low in every IDLE cycle without a transfer in the previous cycle; ram_addr/ram_wdata hold their last values.
REQ-021 clear_req high in IDLE takes priority over all valids: both readies are low that cycle; next state is CLEAR; err_addr clears.
REQ-022 CLEAR: both readies low; ram_we=1, ram_wdata=CLEAR_VALUE, ram_addr counting 0..NUM_TILES-1, one address per cycle.
REQ-023 After address NUM_TILES-1 is written: clear_done pulses for one cycle, clear_busy falls and state returns to IDLE. Without the gate feature, this occurs exactly NUM_TILES cycles after entry.
REQ-024 clear_req asserted while in CLEAR is ignored; it neither restarts nor extends the sequence.
REQ-025 Pending valids are never dropped; they wait with valid held until ready.

Reset
REQ-026 reset_n low asynchronously forces the following values: state IDLE; ram_we 0; ram_addr 0; ram_wdata 0; a_ready 0; b_ready 0; clear_busy 0; clear_done 0; err_addr 0; last_grant B, so channel A wins the first tie.
REQ-027 Reset during CLEAR abandons the sequence; no clear is restarted after reset release.

Configuration
REQ-028 Macro TILE_VBLANK_GATE_EN defined: readies are forced low while vid_on=1. In CLEAR, ram_we is low and the address counter holds while vid_on=1; the sequence resumes at the held address when vid_on=0.
REQ-029 Macro TILE_VBLANK_GATE_EN undefined: vid_on is ignored and writes proceed in any cycle.

Verification
REQ-030 A-only write: a_valid with a_addr=8'd5 and a_data=4'h3 -> a_ready=1; next cycle ram_we=1, ram_addr=5, ram_wdata=3.
REQ-031 Tie: a_valid and b_valid held for 4 cycles -> grants A,B,A,B; ram_we high for 4 consecutive cycles.
REQ-032 Clear: clear_req pulse with a_valid held -> a_ready stays low; 200 writes of 4'h0 at addresses 0..199; clear_done pulse; then A is granted.
REQ-033 Bad address: a_addr=8'd200 accepted -> ram_we=0 and err_addr=1; err_addr stays 1 until the next clear_req.
REQ-034 Gate (TILE_VBLANK_GATE_EN): vid_on=1 -> readies 0; during CLEAR, toggling vid_on stalls the address counter and no address is skipped or repeated.
REQ-035 Reset mid-clear at address 50 -> all outputs return to reset values immediately; state is IDLE after reset_n rises.

Source files
------------

// File: rtl/tile_write_arbiter_if.sv
// Tile write request bundle: two independent valid/ready write channels
// (A = local game logic, B = remote link) feeding the tile RAM arbiter.
// The arbiter connects through the slave modport; requesters use master.
interface tile_write_arbiter_if;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] a_addr;
    logic [3:0] a_data;

    logic       b_valid;
    logic       b_ready;
    logic [7:0] b_addr;
    logic [3:0] b_data;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/tile_write_arbiter.sv
// Tile RAM write arbiter.
// Round-robin arbitration between the local (A) and remote (B) write
// channels into a single registered RAM write port, plus a board-clear
// sequencer that sweeps every tile address with CLEAR_VALUE.
// Optional feature macro: TILE_VBLANK_GATE_EN -- when defined, all tile
// RAM writes (channel writes and clear writes) are confined to vid_on=0.
module tile_write_arbiter #(
    parameter int         NUM_TILES   = 200,
    parameter logic [3:0] CLEAR_VALUE = 4'h0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       vid_on,
    input  logic                       clear_req,
    output logic                       clear_busy,
    output logic                       clear_done,
    tile_write_arbiter_if.slave        wr,
    output logic                       ram_we,
    output logic [7:0]                 ram_addr,
    output logic [3:0]                 ram_wdata,
    output logic                       err_addr
);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    typedef enum logic {
        GRANT_A,
        GRANT_B
    } grant_e;

    localparam logic [8:0] NUM_TILES_W = 9'(NUM_TILES);
    localparam logic [7:0] LAST_ADDR   = 8'(NUM_TILES - 1);

    state_e     state_q;
    state_e     state_d;
    grant_e     last_grant_q;
    logic       ram_we_q;
    logic       gate_block;
    logic       clear_stall;
    logic       clear_last;
    logic       a_xfer;
    logic       b_xfer;
    logic [7:0] xfer_addr;
    logic [3:0] xfer_data;
    logic       xfer_addr_ok;

`ifdef TILE_VBLANK_GATE_EN
    // Active video owns the tile RAM; writes are only allowed in blanking.
    assign gate_block = vid_on;
`else
    // Without the gate, writes may land in any cycle and vid_on is a don't-care.
    logic unused_vid_on;
    assign unused_vid_on = vid_on;
    assign gate_block    = 1'b0;
`endif

    // A clear cycle stalls (no write, address held) while the gate blocks.
    assign clear_stall = (state_q == ST_CLEAR) && gate_block;
    assign clear_last  = (state_q == ST_CLEAR) && !clear_stall && (ram_addr == LAST_ADDR);

    // The registered write strobe is masked during a stalled clear cycle so
    // the held address is never written twice.
    assign ram_we = ram_we_q && !clear_stall;

    // Grant logic: one ready at most, round-robin on a tie, none while
    // clearing, during a clear request, under the gate, or in reset.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        wr.a_ready = 1'b0;
        wr.b_ready = 1'b0;
        if (reset_n && (state_q == ST_IDLE) && !clear_req && !gate_block) begin
            if (wr.a_valid && wr.b_valid) begin
                if (last_grant_q == GRANT_B) begin
                    wr.a_ready = 1'b1;
                end else begin
                    wr.b_ready = 1'b1;
                end
            end else begin
                wr.a_ready = wr.a_valid;
                wr.b_ready = wr.b_valid;
            end
        end
    end

    // Transfer detection and selection of the winning channel's payload.
    always_comb begin
        a_xfer       = wr.a_valid && wr.a_ready;
        b_xfer       = wr.b_valid && wr.b_ready;
        xfer_addr    = b_xfer ? wr.b_addr : wr.a_addr;
        xfer_data    = b_xfer ? wr.b_data : wr.a_data;
        xfer_addr_ok = ({1'b0, xfer_addr} < NUM_TILES_W);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state is assigned with non-blocking (<=) so every
        // register samples its inputs from before the clock edge.
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a clear request always wins in IDLE; a clear ends
    // after its final address has been presented.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clear_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write port, clear sequencer, grant history and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_we_q     <= 1'b0;
            ram_addr     <= 8'd0;
            ram_wdata    <= 4'h0;
            clear_busy   <= 1'b0;
            clear_done   <= 1'b0;
            err_addr     <= 1'b0;
            last_grant_q <= GRANT_B;
        end else begin
            clear_done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clear_req) begin
                        // First clear write is presented in the first CLEAR cycle.
                        ram_we_q   <= 1'b1;
                        ram_addr   <= 8'd0;
                        ram_wdata  <= CLEAR_VALUE;
                        clear_busy <= 1'b1;
                        err_addr   <= 1'b0;
                    end else if (a_xfer || b_xfer) begin
                        last_grant_q <= b_xfer ? GRANT_B : GRANT_A;
                        if (xfer_addr_ok) begin
                            ram_we_q  <= 1'b1;
                            ram_addr  <= xfer_addr;
                            ram_wdata <= xfer_data;
                        end else begin
                            // Out-of-range write is swallowed and flagged.
                            ram_we_q <= 1'b0;
                            err_addr <= 1'b1;
                        end
                    end else begin
                        ram_we_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (clear_last) begin
                        ram_we_q   <= 1'b0;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else if (!clear_stall) begin
                        ram_addr <= ram_addr + 8'd1;
                    end
                end
                default: ram_we_q <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_write_arbiter.sv
// Directed testbench for tile_write_arbiter (NUM_TILES=200, CLEAR_VALUE=0).
// Inputs change 2 time units after a rising edge; outputs are sampled
// 1 unit later, well clear of either clock edge.
module tb_tile_write_arbiter;

    logic       clk;
    logic       reset_n;
    logic       vid_on;
    logic       clear_req;
    logic       clear_busy;
    logic       clear_done;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [3:0] ram_wdata;
    logic       err_addr;

    int tests_run    = 0;
    int tests_failed = 0;

    tile_write_arbiter_if wr_if ();

    tile_write_arbiter #(
        .NUM_TILES   (200),
        .CLEAR_VALUE (4'h0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vid_on     (vid_on),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .wr         (wr_if),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .err_addr   (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_addr;

        // ---- reset values, with both channels requesting ----
        reset_n         = 1'b0;
        vid_on          = 1'b0;
        clear_req       = 1'b0;
        wr_if.a_valid   = 1'b1;
        wr_if.a_addr    = 8'd5;
        wr_if.a_data    = 4'h3;
        wr_if.b_valid   = 1'b1;
        wr_if.b_addr    = 8'd7;
        wr_if.b_data    = 4'h9;
        #3;
        check("rst_ram_we",     32'(ram_we),     0);
        check("rst_ram_addr",   32'(ram_addr),   0);
        check("rst_ram_wdata",  32'(ram_wdata),  0);
        check("rst_a_ready",    32'(wr_if.a_ready), 0);
        check("rst_b_ready",    32'(wr_if.b_ready), 0);
        check("rst_clear_busy", 32'(clear_busy), 0);
        check("rst_clear_done", 32'(clear_done), 0);
        check("rst_err_addr",   32'(err_addr),   0);

        cyc();
        reset_n       = 1'b1;
        wr_if.a_valid = 1'b0;
        wr_if.b_valid = 1'b0;

        // ---- A-only write: addr 5, data 3 ----
        cyc();
        wr_if.a_valid = 1'b1;
        #1;
        check("a_only_a_ready", 32'(wr_if.a_ready), 1);
        check("a_only_b_ready", 32'(wr_if.b_ready), 0);
        check("a_only_no_we",   32'(ram_we), 0);
        cyc();
        wr_if.a_valid = 1'b0;
        #1;
        check("a_only_we",    32'(ram_we),    1);
        check("a_only_addr",  32'(ram_addr),  5);
        check("a_only_wdata", 32'(ram_wdata), 3);
        cyc();
        #1;
        check("idle_we_low",    32'(ram_we),    0);
        check("idle_addr_hold", 32'(ram_addr),  5);
        check("idle_data_hold", 32'(ram_wdata), 3);

        // ---- B-only write: addr 7, data 9 ----
        cyc();
        wr_if.b_valid = 1'b1;
        #1;
        check("b_only_b_ready", 32'(wr_if.b_ready), 1);
        check("b_only_a_ready", 32'(wr_if.a_ready), 0);
        cyc();
        wr_if.b_valid = 1'b0;
        #1;
        check("b_only_write", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 8'd7, 4'h9}));

        // ---- tie held for 4 cycles: last grant was B, so A,B,A,B ----
        cyc();
        wr_if.a_valid = 1'b1;
        wr_if.a_addr  = 8'd10;
        wr_if.a_data  = 4'h1;
        wr_if.b_valid = 1'b1;
        wr_if.b_addr  = 8'd20;
        wr_if.b_data  = 4'h2;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("tie_a_ready", 32'(wr_if.a_ready), 32'((k % 2) == 0));
            check("tie_b_ready", 32'(wr_if.b_ready), 32'((k % 2) == 1));
            if (k > 0) begin
                if (((k - 1) % 2) == 0) begin
                    check("tie_write_a", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 8'd10, 4'h1}));
                end else begin
                    check("tie_write_b", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 8'd20, 4'h2}));
                end
            end
            cyc();
        end
        wr_if.a_valid = 1'b0;
        wr_if.b_valid = 1'b0;
        #1;
        check("tie_write_last", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 8'd20, 4'h2}));

        // ---- out-of-range address 200 ----
        cyc();
        wr_if.a_valid = 1'b1;
        wr_if.a_addr  = 8'd200;
        wr_if.a_data  = 4'h7;
        #1;
        check("bad_a_ready", 32'(wr_if.a_ready), 1);
        cyc();
        wr_if.a_valid = 1'b0;
        #1;
        check("bad_we_low",    32'(ram_we),   0);
        check("bad_err_addr",  32'(err_addr), 1);
        check("bad_addr_hold", 32'(ram_addr), 20);

        // ---- highest legal address 199 ----
        cyc();
        wr_if.a_valid = 1'b1;
        wr_if.a_addr  = 8'd199;
        wr_if.a_data  = 4'h4;
        cyc();
        wr_if.a_valid = 1'b0;
        #1;
        check("edge_199_write", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 8'd199, 4'h4}));
        cyc();
        cyc();
        #1;
        check("err_addr_sticky", 32'(err_addr), 1);

        // ---- full clear with A pending; clear_req re-pulsed mid-clear ----
        cyc();
        wr_if.a_valid = 1'b1;
        wr_if.a_addr  = 8'd3;
        wr_if.a_data  = 4'h5;
        clear_req     = 1'b1;
        #1;
        check("clr_req_a_ready", 32'(wr_if.a_ready), 0);
        check("clr_req_b_ready", 32'(wr_if.b_ready), 0);
        cyc();
        clear_req = 1'b0;
        for (int i = 0; i < 200; i++) begin
            clear_req = (i == 100);
            #1;
            check("clear_write", 32'({ram_we, clear_busy, wr_if.a_ready, ram_wdata, ram_addr}),
                  32'({1'b1, 1'b1, 1'b0, 4'h0, 8'(i)}));
            if (i == 0) begin
                check("clear_err_cleared", 32'(err_addr), 0);
            end
            cyc();
        end
        clear_req = 1'b0;
        #1;
        check("clear_done_pulse", 32'(clear_done), 1);
        check("clear_busy_fall",  32'(clear_busy), 0);
        check("clear_end_we",     32'(ram_we),     0);
        check("clear_end_grant",  32'(wr_if.a_ready), 1);
        cyc();
        wr_if.a_valid = 1'b0;
        #1;
        check("clear_done_single", 32'(clear_done), 0);
        check("post_clear_write", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 8'd3, 4'h5}));
        cyc();
        #1;
        check("clear_not_restarted", 32'(clear_busy), 0);

        // ---- reset in the middle of a clear, at address 50 ----
        cyc();
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc();
        end
        #1;
        check("mid_clear_addr", 32'({ram_we, ram_addr}), 32'({1'b1, 8'd50}));
        wr_if.a_valid = 1'b1;
        wr_if.b_valid = 1'b1;
        reset_n       = 1'b0;
        #1;
        check("mid_rst_outputs",
              32'({ram_we, ram_addr, ram_wdata, wr_if.a_ready, wr_if.b_ready, clear_busy, clear_done, err_addr}),
              0);
        cyc();
        cyc();
        reset_n = 1'b1;
        #1;
        check("post_rst_tie_a", 32'(wr_if.a_ready), 1);
        check("post_rst_tie_b", 32'(wr_if.b_ready), 0);
        check("post_rst_busy",  32'(clear_busy),    0);
        cyc();
        wr_if.a_valid = 1'b0;
        wr_if.b_valid = 1'b0;
        #1;
        check("post_rst_write", 32'({clear_busy, ram_we, ram_addr, ram_wdata}), 32'({1'b0, 1'b1, 8'd3, 4'h5}));

`ifdef TILE_VBLANK_GATE_EN
        // ---- vblank gate: no readies in active video, clear stalls ----
        cyc();
        vid_on        = 1'b1;
        wr_if.a_valid = 1'b1;
        wr_if.a_addr  = 8'd9;
        wr_if.a_data  = 4'h6;
        #1;
        check("gate_a_ready_low", 32'(wr_if.a_ready), 0);
        cyc();
        vid_on = 1'b0;
        #1;
        check("gate_a_ready_blank", 32'(wr_if.a_ready), 1);
        cyc();
        wr_if.a_valid = 1'b0;
        clear_req     = 1'b1;
        cyc();
        clear_req = 1'b0;
        exp_addr  = 0;
        for (int i = 0; i < 600; i++) begin
            vid_on = ((i % 3) == 1);
            #1;
            if (!clear_busy) break;
            if (vid_on) begin
                check("gate_clear_stall", 32'(ram_we), 0);
            end else begin
                check("gate_clear_write", 32'({ram_we, ram_addr}), 32'({1'b1, 8'(exp_addr)}));
                exp_addr++;
            end
            cyc();
        end
        vid_on = 1'b0;
        check("gate_clear_count", 32'(exp_addr), 200);
        check("gate_clear_done",  32'(clear_done), 1);
`else
        // ---- without the gate, vid_on has no effect on writes ----
        exp_addr = 9;
        cyc();
        vid_on        = 1'b1;
        wr_if.a_valid = 1'b1;
        wr_if.a_addr  = 8'd9;
        wr_if.a_data  = 4'h6;
        #1;
        check("vid_on_ignored_ready", 32'(wr_if.a_ready), 1);
        cyc();
        wr_if.a_valid = 1'b0;
        #1;
        check("vid_on_ignored_write", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 8'(exp_addr), 4'h6}));
        vid_on = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
